// File: rtl/bif_master.sv
// Bus initiator for the bif register bus: one read or write transaction per accepted command.
// Latency: write response 2 cycles after accept, read 3 (nominal) or TIMEOUT_CYC+2 (timeout).
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready, one transaction outstanding.
`timescale 1ns/1ps
module bif_master #(
  parameter int BUS_AWID    = 8,
  parameter int BUS_DWID    = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_WID     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [BUS_AWID-1:0] cmd_addr,
  input  logic [BUS_DWID-1:0] cmd_wdat,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_wr,
  output logic [BUS_DWID-1:0] rsp_rdat,
  output logic                rsp_err,
  output logic [BUS_AWID-1:0] bif_addr,
  output logic                bif_sel,
  output logic                bif_wr_ev,
  output logic                bif_rd_ev,
  output logic [BUS_DWID-1:0] bif_wr_dat,
  input  logic [BUS_DWID-1:0] bif_rd_dat,
  input  logic                bif_rd_vld_ev,
  output logic                busy,
  output logic [CNT_WID-1:0]  stat_to_cnt
);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RSP} state_t;

  state_t              state, state_nxt;
  logic [7:0]          wait_cnt, wait_cnt_nxt;
  logic [BUS_AWID-1:0] bif_addr_nxt;
  logic [BUS_DWID-1:0] bif_wr_dat_nxt, rsp_rdat_nxt;
  logic                bif_sel_nxt, bif_wr_ev_nxt, bif_rd_ev_nxt;
  logic                rsp_valid_nxt, rsp_wr_nxt, rsp_err_nxt;
  logic [CNT_WID-1:0]  stat_to_cnt_nxt;

  localparam logic [7:0]         LAST_WAIT = 8'(TIMEOUT_CYC - 1);
  localparam logic [CNT_WID-1:0] CNT_ONE   = {{(CNT_WID-1){1'b0}}, 1'b1};

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // State, counter and all registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      bif_addr    <= '0;
      bif_wr_dat  <= '0;
      bif_sel     <= 1'b0;
      bif_wr_ev   <= 1'b0;
      bif_rd_ev   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_wr      <= 1'b0;
      rsp_rdat    <= '0;
      rsp_err     <= 1'b0;
      stat_to_cnt <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      bif_addr    <= bif_addr_nxt;
      bif_wr_dat  <= bif_wr_dat_nxt;
      bif_sel     <= bif_sel_nxt;
      bif_wr_ev   <= bif_wr_ev_nxt;
      bif_rd_ev   <= bif_rd_ev_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_wr      <= rsp_wr_nxt;
      rsp_rdat    <= rsp_rdat_nxt;
      rsp_err     <= rsp_err_nxt;
      stat_to_cnt <= stat_to_cnt_nxt;
    end
  end

  // Next state and next output values; strobes default low so they last a single cycle.
  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    bif_addr_nxt    = bif_addr;
    bif_wr_dat_nxt  = bif_wr_dat;
    bif_sel_nxt     = 1'b0;
    bif_wr_ev_nxt   = 1'b0;
    bif_rd_ev_nxt   = 1'b0;
    rsp_valid_nxt   = rsp_valid;
    rsp_wr_nxt      = rsp_wr;
    rsp_rdat_nxt    = rsp_rdat;
    rsp_err_nxt     = rsp_err;
    stat_to_cnt_nxt = stat_to_cnt;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          bif_addr_nxt   = cmd_addr;
          bif_wr_dat_nxt = cmd_wdat;
          rsp_wr_nxt     = cmd_wr;
          bif_sel_nxt    = 1'b1;
          if (cmd_wr) begin
            bif_wr_ev_nxt = 1'b1;
            state_nxt     = WR;
          end else begin
            bif_rd_ev_nxt = 1'b1;
            state_nxt     = RD_ISSUE;
          end
        end
      end
      WR: begin
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = 1'b0;
        rsp_rdat_nxt  = '0;
        state_nxt     = RSP;
      end
      RD_ISSUE: begin
        wait_cnt_nxt = '0;
        state_nxt    = RD_WAIT;
      end
      RD_WAIT: begin
        wait_cnt_nxt = wait_cnt + 8'd1;
        // A read-valid in the final wait cycle still counts as a successful read.
        if (bif_rd_vld_ev) begin
          rsp_rdat_nxt  = bif_rd_dat;
          rsp_err_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RSP;
        end else if (wait_cnt == LAST_WAIT) begin
          rsp_rdat_nxt  = '0;
          rsp_err_nxt   = 1'b1;
          rsp_valid_nxt = 1'b1;
          if (stat_to_cnt != {CNT_WID{1'b1}}) stat_to_cnt_nxt = stat_to_cnt + CNT_ONE;
          state_nxt     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/bif_master.md
Name: bif_master

Overview:
- Bus-initiator for the simple register bus (bif_*) used by the generated register-file slaves.
- Accepts single read/write commands on a valid/ready request channel and drives one bif transaction per command.
- For reads, waits for the slave's read-valid pulse, with a timeout for unmapped addresses (slave never pulses).
- Returns one response per command on a valid/ready response channel. Sits between a host-side controller (UART/SPI bridge, CPU shim) and the register-file slaves.

Parameters:
- BUS_AWID, 8, bif address width
- BUS_DWID, 32, bif data width
- TIMEOUT_CYC, 16, max RD_WAIT cycles before a read is declared failed; legal range 2..255
- CNT_WID, 8, width of saturating timeout statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_wr  in  1  1=write, 0=read
- cmd_addr  in  BUS_AWID  target address
- cmd_wdat  in  BUS_DWID  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
- rsp_wr  out  1  echo of cmd_wr
- rsp_rdat  out  BUS_DWID  read data; 0 for writes and timeouts
- rsp_err  out  1  1=read timeout
- bif_addr  out  BUS_AWID  bus address
- bif_sel  out  1  slave select, high during the ev pulse
- bif_wr_ev  out  1  one-cycle write strobe
- bif_rd_ev  out  1  one-cycle read strobe
- bif_wr_dat  out  BUS_DWID  bus write data
- bif_rd_dat  in  BUS_DWID  slave read data, valid with bif_rd_vld_ev
- bif_rd_vld_ev  in  1  slave read-valid pulse
- busy  out  1  state!=IDLE
- stat_to_cnt  out  CNT_WID  saturating count of read timeouts

Behaviour:
- Reset values:
  - All outputs 0 except cmd_ready=1. bif_addr=0, bif_wr_dat=0, stat_to_cnt=0.
  - FSM to IDLE. Wait counter 0.
- All outputs are registered except cmd_ready (=state==IDLE) and busy.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RSP.
- IDLE:
  - On cmd_valid: latch cmd_addr into bif_addr, cmd_wdat into bif_wr_dat, cmd_wr into rsp_wr.
  - Go to WR if cmd_wr=1, else RD_ISSUE. Drive bif_sel/bif_wr_ev/bif_rd_ev high in the same registered update.
  - bif_addr/bif_wr_dat hold until the next accepted command.
- WR:
  - bif_sel=1 and bif_wr_ev=1 for exactly this cycle.
  - Next: RSP with rsp_valid=1, rsp_err=0, rsp_rdat=0.
- RD_ISSUE:
  - bif_sel=1 and bif_rd_ev=1 for exactly this cycle. Clear the wait counter.
  - Next: RD_WAIT.
- RD_WAIT:
  - bif_sel=0, strobes 0. Counter increments each cycle.
  - If bif_rd_vld_ev=1: capture bif_rd_dat into rsp_rdat, rsp_err=0, go to RSP. Nominal slave answers in the first RD_WAIT cycle.
  - Else if counter==TIMEOUT_CYC-1: rsp_err=1, rsp_rdat=0, stat_to_cnt+1 (saturate at all-ones), go to RSP.
  - If vld and the timeout cycle coincide, vld wins (no error).
- RSP:
  - rsp_valid held with stable rsp_* until rsp_ready. On handshake: rsp_valid=0, go to IDLE.
  - Next command accepted the cycle after the handshake. No overlap, one outstanding transaction.
- Latencies (accept at cycle 0, rsp_ready tied 1):
  - Write: strobe at cycle 1, rsp_valid at cycle 2.
  - Nominal read: rd_ev at cycle 1, vld at cycle 2, rsp_valid at cycle 3.
  - Timeout read: rsp_valid at cycle 1+TIMEOUT_CYC+1.
- bif_rd_vld_ev in any state other than RD_WAIT is ignored: no data capture, no state change.
- A late vld arriving after a timeout is dropped.
- cmd_* is ignored when cmd_ready=0.
- Reset mid-transaction aborts immediately: strobes low, no response emitted, stat_to_cnt cleared.

Test Plan:
- Write: cmd_wr=1, addr=0x04, wdat=0xDEADBEEF -> cycle 1: bif_sel=bif_wr_ev=1, bif_addr=0x04, bif_wr_dat=0xDEADBEEF, one cycle only. Cycle 2: rsp_valid=1, rsp_wr=1, rsp_err=0.
- Read: cmd_wr=0, addr=0x08; slave model returns 0x12345678 one cycle after rd_ev -> rsp_valid at cycle 3, rsp_rdat=0x12345678, rsp_err=0.
- Timeout: read addr=0xFF, slave never pulses vld -> rsp_valid at cycle 18 (TIMEOUT_CYC=16), rsp_err=1, rsp_rdat=0, stat_to_cnt=1. Repeat 300 times -> stat_to_cnt saturates at 255.
- Backpressure: rsp_ready=0 for 10 cycles after a read -> rsp_* stable, cmd_ready=0, second cmd_valid not accepted. Release -> second command accepted the cycle after the handshake.
- Stray/late vld: pulse bif_rd_vld_ev with 0xAAAA5555 while IDLE, and at the cycle after a timeout -> no state change, no response, rsp_rdat unchanged.
- Reset mid-read: assert rst in RD_WAIT -> outputs at reset values next edge, no rsp_valid. A fresh read after release completes normally.
